// File: rtl/axis_test_pkg.sv
// Shared definitions for the stream test sink and the future counting source.
package axis_test_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } chk_state_t;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One right-shift step of a 16-bit Galois LFSR
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur, input logic [15:0] taps);
    logic [15:0] shifted;
    shifted = cur >> 1;
    return cur[0] ? (shifted ^ taps) : shifted;
  endfunction

endpackage

// File: rtl/axi_stream_seq_checker_lfsr16.sv
// Free-running 16-bit Galois LFSR; exposes the low bits of the value it will
// hold after the next clock edge so callers can register decisions on it.
module lfsr16
  import axis_test_pkg::*;
#(
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter logic [15:0] TAPS     = LFSR_TAPS,
  parameter int          OUT_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  output logic [OUT_BITS-1:0] next_bits
);

  logic [15:0] state;
  logic [15:0] state_next;

  assign state_next = lfsr_next(state, TAPS);
  assign next_bits  = state_next[OUT_BITS-1:0];

  // Advance every cycle regardless of what the consumer is doing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEED;
    end else begin
      state <= state_next;
    end
  end

endmodule

// File: rtl/axi_stream_seq_checker.sv
// AXI-stream sink: LFSR-modulated backpressure, incrementing-sequence checker
// and an independent upstream valid/data stability monitor.
module axi_stream_seq_checker
  import axis_test_pkg::*;
#(
  parameter int          DATA_BITS   = 32,
  parameter int          COUNT_BITS  = 16,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_tvalid,
  output logic                  in_tready,
  input  logic [DATA_BITS-1:0]  in_tdata,
  input  logic                  enable,
  input  logic [3:0]            stall_level,
  input  logic                  load,
  input  logic [DATA_BITS-1:0]  expect_init,
  output logic [COUNT_BITS-1:0] xfer_count,
  output logic [COUNT_BITS-1:0] seq_err_count,
  output logic                  proto_err,
  output logic                  halted,
  output logic [DATA_BITS-1:0]  err_expected,
  output logic [DATA_BITS-1:0]  err_got
);

  localparam logic [COUNT_BITS-1:0] COUNT_ONE = COUNT_BITS'(1);
  localparam logic [DATA_BITS-1:0]  DATA_ONE  = DATA_BITS'(1);

  // Counters stick at all-ones instead of wrapping
  function automatic logic [COUNT_BITS-1:0] sat_inc(input logic [COUNT_BITS-1:0] cnt);
    return (&cnt) ? cnt : cnt + COUNT_ONE;
  endfunction

  chk_state_t           state;
  chk_state_t           state_nxt;
  logic [3:0]           lfsr_low_nxt;
  logic [DATA_BITS-1:0] expected;
  logic                 first_err;
  logic                 handshake;
  logic                 beat_check;
  logic                 beat_bad;
  logic                 ready_nxt;
  logic                 mon_live;
  logic                 prev_stall;
  logic [DATA_BITS-1:0] prev_data;
  logic                 violation;

  lfsr16 #(
    .SEED     (LFSR_SEED),
    .TAPS     (LFSR_TAPS),
    .OUT_BITS (4)
  ) u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .next_bits (lfsr_low_nxt)
  );

  // A beat taken in a load cycle is consumed but never checked
  assign handshake  = in_tvalid && in_tready;
  assign beat_check = handshake && !load;
  assign beat_bad   = beat_check && (in_tdata != expected);
  assign halted     = (state == HALT);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a stop-on-error halt outranks a simultaneous disable
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (enable) state_nxt = RUN;
      RUN: begin
        if (STOP_ON_ERR && beat_bad) begin
          state_nxt = HALT;
        end else if (!enable) begin
          state_nxt = IDLE;
        end
      end
      HALT: if (load) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready for the coming cycle, gated by the LFSR value that cycle will see
  always_comb begin
    ready_nxt = 1'b0;
    if ((state_nxt == RUN) && !load) begin
      ready_nxt = (stall_level == 4'd0) || (lfsr_low_nxt >= stall_level);
    end
  end

  // Registered ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_tready <= 1'b0;
    end else begin
      in_tready <= ready_nxt;
    end
  end

  // Sequence checker: resync to received data on mismatch so a single drop costs one error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      expected      <= '0;
      xfer_count    <= '0;
      seq_err_count <= '0;
      first_err     <= 1'b0;
      err_expected  <= '0;
      err_got       <= '0;
    end else if (load) begin
      expected      <= expect_init;
      xfer_count    <= '0;
      seq_err_count <= '0;
      first_err     <= 1'b0;
      err_expected  <= '0;
      err_got       <= '0;
    end else if (beat_check) begin
      xfer_count <= sat_inc(xfer_count);
      if (beat_bad) begin
        seq_err_count <= sat_inc(seq_err_count);
        expected      <= in_tdata + DATA_ONE;
        if (!first_err) begin
          err_expected <= expected;
          err_got      <= in_tdata;
          first_err    <= 1'b1;
        end
      end else begin
        expected <= expected + DATA_ONE;
      end
    end
  end

  // Upstream must not raise valid in the first cycle out of reset, and must
  // hold valid and data steady while stalled
  assign violation = mon_live ? (prev_stall && (!in_tvalid || (in_tdata != prev_data)))
                              : in_tvalid;

  // Protocol monitor history and sticky flag; load clears even a same-cycle violation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mon_live   <= 1'b0;
      prev_stall <= 1'b0;
      prev_data  <= '0;
      proto_err  <= 1'b0;
    end else begin
      mon_live   <= 1'b1;
      prev_stall <= in_tvalid && !in_tready;
      prev_data  <= in_tdata;
      if (load) begin
        proto_err <= 1'b0;
      end else if (violation) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axi_stream_seq_checker.sv
// Directed bench: two checker instances share control inputs; dut0 resyncs
// on error, dut1 halts on error. Each has its own upstream valid/data.
module tb_axi_stream_seq_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        load;
  logic [3:0]  stall_level;
  logic [31:0] expect_init;

  logic        v0, r0, proto0, halt0;
  logic [31:0] d0, eexp0, egot0;
  logic [15:0] xfer0, serr0;

  logic        v1, r1, proto1, halt1;
  logic [31:0] d1, eexp1, egot1;
  logic [15:0] xfer1, serr1;

  int total = 0;
  int bad = 0;
  int stall_seen = 0;
  int ready_cnt = 0;

  always #5 clk = ~clk;

  axi_stream_seq_checker #(
    .DATA_BITS(32), .COUNT_BITS(16), .LFSR_SEED(16'hACE1), .STOP_ON_ERR(1'b0)
  ) dut0 (
    .clk(clk), .rst(rst), .in_tvalid(v0), .in_tready(r0), .in_tdata(d0),
    .enable(enable), .stall_level(stall_level), .load(load), .expect_init(expect_init),
    .xfer_count(xfer0), .seq_err_count(serr0), .proto_err(proto0), .halted(halt0),
    .err_expected(eexp0), .err_got(egot0)
  );

  axi_stream_seq_checker #(
    .DATA_BITS(32), .COUNT_BITS(16), .LFSR_SEED(16'hACE1), .STOP_ON_ERR(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst), .in_tvalid(v1), .in_tready(r1), .in_tdata(d1),
    .enable(enable), .stall_level(stall_level), .load(load), .expect_init(expect_init),
    .xfer_count(xfer1), .seq_err_count(serr1), .proto_err(proto1), .halted(halt1),
    .err_expected(eexp1), .err_got(egot1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_load(input logic [31:0] init);
    expect_init = init;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Present one beat on the chosen instance and hold it until accepted
  task automatic send(input int which, input logic [31:0] val);
    int guard;
    guard = 0;
    if (which == 0) begin v0 = 1'b1; d0 = val; end
    else begin v1 = 1'b1; d1 = val; end
    while (((which == 0) ? r0 : r1) !== 1'b1 && guard < 300) begin
      @(negedge clk);
      guard++;
      stall_seen++;
    end
    if (guard >= 300) begin
      total++;
      bad++;
      $error("FAIL send_timeout: ready never seen for value %0h (dut%0d)", val, which);
    end
    @(negedge clk);
    if (which == 0) v0 = 1'b0;
    else v1 = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; load = 1'b0; stall_level = 4'd0; expect_init = '0;
    v0 = 1'b0; d0 = '0; v1 = 1'b0; d1 = '0;
    tick(); tick();

    // Reset state
    chk("rst_ready", r0, 0);
    chk("rst_xfer", xfer0, 0);
    chk("rst_serr", serr0, 0);
    chk("rst_proto", proto0, 0);
    chk("rst_halt", halt1, 0);
    rst = 1'b0;
    tick(); tick();
    chk("idle_ready", r0, 0);
    chk("idle_proto", proto0, 0);

    // 1: no backpressure, 0..99 back-to-back
    enable = 1'b1; stall_level = 4'd0;
    pulse_load(32'd0);
    tick(); tick();
    stall_seen = 0;
    for (int i = 0; i < 100; i++) send(0, i);
    chk("t1_xfer", xfer0, 100);
    chk("t1_serr", serr0, 0);
    chk("t1_no_stall", stall_seen, 0);
    chk("t1_ready", r0, 1);

    // 2: stall_level 8 gives roughly half-duty ready
    stall_level = 4'd8;
    pulse_load(32'd0);
    stall_seen = 0;
    for (int i = 0; i < 100; i++) send(0, i);
    chk("t2_xfer", xfer0, 100);
    chk("t2_serr", serr0, 0);
    chk("t2_stalls_seen", (stall_seen > 0), 1);
    ready_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (r0 === 1'b1) ready_cnt++;
    end
    chk("t2_duty_400_600", (ready_cnt >= 400 && ready_cnt <= 600), 1);

    // 3: value 5 dropped, checker resyncs and keeps running
    stall_level = 4'd0;
    pulse_load(32'd0);
    tick();
    for (int i = 0; i <= 10; i++) if (i != 5) send(0, i);
    chk("t3_xfer", xfer0, 10);
    chk("t3_serr", serr0, 1);
    chk("t3_err_expected", eexp0, 5);
    chk("t3_err_got", egot0, 6);
    chk("t3_not_halted", halt0, 0);
    chk("t3_ready", r0, 1);
    send(0, 11);
    chk("t3_resync_serr", serr0, 1);
    chk("t3_resync_xfer", xfer0, 11);
    send(0, 20);
    chk("t3_second_serr", serr0, 2);
    chk("t3_first_kept_exp", eexp0, 5);
    chk("t3_first_kept_got", egot0, 6);

    // load coincident with a handshake: beat swallowed, not counted
    chk("ld_hs_ready", r0, 1);
    v0 = 1'b1; d0 = 32'h55;
    pulse_load(32'd100);
    v0 = 1'b0;
    chk("ld_hs_xfer", xfer0, 0);
    chk("ld_hs_serr", serr0, 0);
    chk("ld_hs_eexp", eexp0, 0);
    send(0, 100);
    send(0, 101);
    chk("ld_hs_after_xfer", xfer0, 2);
    chk("ld_hs_after_serr", serr0, 0);

    // 4: stop-on-error instance halts after value 6
    pulse_load(32'd0);
    tick();
    for (int i = 0; i <= 4; i++) send(1, i);
    send(1, 6);
    chk("t4_halted", halt1, 1);
    chk("t4_ready_low", r1, 0);
    chk("t4_serr", serr1, 1);
    chk("t4_xfer", xfer1, 6);
    chk("t4_eexp", eexp1, 5);
    chk("t4_egot", egot1, 6);
    tick(); tick(); tick();
    chk("t4_still_halted", halt1, 1);
    chk("t4_still_not_ready", r1, 0);
    pulse_load(32'd0);
    chk("t4_unhalted", halt1, 0);
    chk("t4_xfer_clr", xfer1, 0);
    chk("t4_serr_clr", serr1, 0);
    chk("t4_eexp_clr", eexp1, 0);

    // 5: stability violations while stalled
    enable = 1'b0;
    tick(); tick();
    chk("t5_stalled", r0, 0);
    v0 = 1'b1; d0 = 32'd3;
    tick();
    chk("t5_before", proto0, 0);
    d0 = 32'd4;
    tick();
    chk("t5_data_change", proto0, 1);
    tick(); tick(); tick();
    chk("t5_sticky", proto0, 1);
    pulse_load(32'd0);
    chk("t5_load_clears", proto0, 0);
    v0 = 1'b0;
    tick();
    chk("t5_valid_drop", proto0, 1);
    pulse_load(32'd0);
    chk("t5_load_clears2", proto0, 0);
    v0 = 1'b1; d0 = 32'd7;
    tick();
    v0 = 1'b0;
    pulse_load(32'd0);
    chk("t5_load_beats_violation", proto0, 0);
    tick();
    chk("t5_stays_clear", proto0, 0);

    // 6: expected wraps through zero
    enable = 1'b1;
    pulse_load(32'hFFFF_FFFE);
    tick();
    send(0, 32'hFFFF_FFFE);
    send(0, 32'hFFFF_FFFF);
    send(0, 32'h0000_0000);
    send(0, 32'h0000_0001);
    chk("t6_wrap_serr", serr0, 0);
    chk("t6_wrap_xfer", xfer0, 4);
    send(0, 32'd9);
    chk("t6_wrap_eexp", eexp0, 2);
    chk("t6_wrap_egot", egot0, 9);

    // mid-stream asynchronous reset, beat still presented
    v0 = 1'b1; d0 = 32'd10;
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_xfer", xfer0, 0);
    chk("t6_rst_serr", serr0, 0);
    chk("t6_rst_ready", r0, 0);
    chk("t6_rst_eexp", eexp0, 0);
    chk("t6_rst_egot", egot0, 0);
    chk("t6_rst_proto", proto0, 0);
    chk("t6_rst_halt", halt0, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_valid_after_reset", proto0, 1);
    chk("t6_other_clean", proto1, 0);
    v0 = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
